// File: rtl/inhibit_controller.sv
// -----------------------------------------------------------------------------
// inhibit_controller
//
// Purpose:
//   Generates the active-low enable_l control for a downstream inhibitor gate.
//   An accepted trigger starts a programmable delay (D cycles).
//   An inhibit window of max(H,1) cycles follows, with enable_l held high.
//   While the window is open, a trigger with retrigger_en set reloads the hold
//   count from the live hold_cycles input.
//   cancel aborts either phase at once.
//   Rising edges of the gated input that arrive while enable_l is high are
//   counted in a saturating counter.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   trigger          start request in IDLE / retrigger during INHIBIT
//   cancel           abort any window and return to IDLE
//   retrigger_en     1: trigger during INHIBIT reloads the hold count
//   delay_cycles     D, latched when a start is accepted
//   hold_cycles      H, latched on accept and on every retrigger
//   in               signal gated by the downstream inhibitor
//   enable_l         1 = inhibit downstream, 0 = pass (registered)
//   busy             1 while in DELAY or INHIBIT (registered)
//   done             one-cycle pulse when a window ends normally (registered)
//   suppressed_count saturating count of suppressed rising edges of in
// -----------------------------------------------------------------------------
module inhibit_controller #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic             cancel,
  input  logic             retrigger_en,
  input  logic [WIDTH-1:0] delay_cycles,
  input  logic [WIDTH-1:0] hold_cycles,
  input  logic             in,
  output logic             enable_l,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] suppressed_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_INHIBIT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] SUP_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] SUP_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             enable_l_reg, enable_l_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] sup_reg, sup_next;
  logic             in_prev_reg;
  logic             clear_sup;
  logic             sup_edge;

  // A hold of zero still produces one inhibit cycle.
  logic [WIDTH-1:0] hold_live;
  assign hold_live = (hold_cycles == '0) ? CNT_ONE : hold_cycles;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      hold_reg     <= '0;
      enable_l_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sup_reg      <= '0;
      in_prev_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      hold_reg     <= hold_next;
      enable_l_reg <= enable_l_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      sup_reg      <= sup_next;
      in_prev_reg  <= in;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // cnt_reg holds the number of cycles left in the current phase, including the
  // one in progress, so the phase ends on the edge where it would reach zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    done_next  = 1'b0;
    clear_sup  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // cancel in IDLE suppresses a simultaneous trigger.
        if (trigger && !cancel) begin
          hold_next = hold_live;
          clear_sup = 1'b1;
          if (delay_cycles == '0) begin
            state_next = ST_INHIBIT;
            cnt_next   = hold_live;
          end else begin
            state_next = ST_DELAY;
            cnt_next   = delay_cycles;
          end
        end
      end

      ST_DELAY: begin
        // trigger has no effect while the delay runs.
        if (cancel) begin
          state_next = ST_IDLE;
        end else if (cnt_reg <= CNT_ONE) begin
          state_next = ST_INHIBIT;
          cnt_next   = hold_reg;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      ST_INHIBIT: begin
        // A retrigger takes priority over the window ending.
        // A retrigger in the last high cycle therefore still extends the window.
        if (cancel) begin
          state_next = ST_IDLE;
        end else if (trigger && retrigger_en) begin
          hold_next = hold_live;
          cnt_next  = hold_live;
        end else if (cnt_reg <= CNT_ONE) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered outputs follow the state being entered.
  // They are therefore valid in the same cycle as the state itself.
  always_comb begin
    enable_l_next = (state_next == ST_INHIBIT);
    busy_next     = (state_next != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Suppressed-edge counter
  // A rising edge of in is counted when it occurs in a cycle where enable_l is
  // high.
  // A cancel edge freezes the count.
  // A new start clears the count, and the clear has priority.
  // ---------------------------------------------------------------------------
  assign sup_edge = enable_l_reg && in && !in_prev_reg && !cancel;

  always_comb begin
    sup_next = sup_reg;
    if (clear_sup) begin
      sup_next = '0;
    end else if (sup_edge && (sup_reg != SUP_MAX)) begin
      sup_next = sup_reg + SUP_ONE;
    end
  end

  assign enable_l         = enable_l_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign suppressed_count = sup_reg;

endmodule

// File: tb/tb_inhibit_controller.sv
// -----------------------------------------------------------------------------
// tb_inhibit_controller
//
// Purpose:
//   Self-checking bench for inhibit_controller.
//   The reference model describes each window as a timeline with an absolute
//   start cycle and end cycle.
//   Directed steps are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_inhibit_controller;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             trigger;
  logic             cancel;
  logic             retrigger_en;
  logic [WIDTH-1:0] delay_cycles;
  logic [WIDTH-1:0] hold_cycles;
  logic             in_s;
  logic             enable_l;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] suppressed_count;

  inhibit_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .trigger          (trigger),
    .cancel           (cancel),
    .retrigger_en     (retrigger_en),
    .delay_cycles     (delay_cycles),
    .hold_cycles      (hold_cycles),
    .in               (in_s),
    .enable_l         (enable_l),
    .busy             (busy),
    .done             (done),
    .suppressed_count (suppressed_count)
  );

  always #5 clk = ~clk;

  // Reference model state. Cycle n is the clock period that follows edge n.
  int n = 0;
  bit m_active = 0;
  int m_start = 0;
  int m_end = -1;
  int m_count = 0;
  bit m_inprev = 0;
  bit m_en = 0;
  bit m_busy = 0;
  bit m_done = 0;

  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic drive(input bit t, input bit c, input bit r, input int d, input int h, input bit i);
    trigger      = t;
    cancel       = c;
    retrigger_en = r;
    delay_cycles = d[WIDTH-1:0];
    hold_cycles  = h[WIDTH-1:0];
    in_s         = i;
  endtask

  // Advance the timeline by one edge using the inputs sampled at that edge.
  task automatic model_step();
    int  hp;
    bit  en_prev;
    n++;
    en_prev = m_en;
    hp = (hold_cycles == 0) ? 1 : int'(hold_cycles);
    if (reset) begin
      m_active = 0;
      m_count  = 0;
      m_done   = 0;
    end else begin
      m_done = 0;
      if (en_prev && in_s && !m_inprev && !cancel && m_count < CNT_MAX) m_count++;
      if (cancel) begin
        m_active = 0;
      end else if (!m_active) begin
        if (trigger) begin
          m_active = 1;
          m_start  = n + int'(delay_cycles);
          m_end    = m_start + hp - 1;
          m_count  = 0;
        end
      end else if (n - 1 >= m_start) begin
        // The period that just ended was a high cycle.
        if (trigger && retrigger_en) m_end = n - 1 + hp;
        else if (n - 1 == m_end) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end
    m_inprev = reset ? 1'b0 : in_s;
    m_en     = m_active && (n >= m_start) && (n <= m_end);
    m_busy   = m_active;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check("enable_l", 32'(enable_l), 32'(m_en));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("suppressed_count", 32'(suppressed_count), 32'(m_count));
    if (enable_l === 1'b1) hi_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic idle(input int cycles);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0);

    // 1. Reset with trigger held and in toggling.
    for (int i = 0; i < 2; i++) begin
      in_s = ~in_s;
      tick();
      check("t1_enable_l", 32'(enable_l), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    idle(3);
    check("t1_after_count", 32'(suppressed_count), 32'd0);

    // 2. D=3, H=4 gives 4 high cycles and then a single done pulse.
    hi_cnt = 0; done_cnt = 0;
    drive(1, 0, 0, 3, 4, 0);
    tick();
    check("t2_busy_k1", 32'(busy), 32'd1);
    idle(12);
    check("t2_high", 32'(hi_cnt), 32'd4);
    check("t2_done", 32'(done_cnt), 32'd1);

    // 3. D=0, H=0 gives 1 high cycle, which starts right after the trigger edge.
    hi_cnt = 0; done_cnt = 0;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    check("t3_en_first", 32'(enable_l), 32'd1);
    idle(5);
    check("t3_high", 32'(hi_cnt), 32'd1);
    check("t3_done", 32'(done_cnt), 32'd1);

    // 4. Retrigger in the 3rd high cycle: 8 high cycles with retrigger_en=1, 5 without.
    for (int r = 1; r >= 0; r--) begin
      hi_cnt = 0; done_cnt = 0;
      drive(1, 0, r[0], 0, 5, 0);
      tick();
      drive(0, 0, r[0], 0, 5, 0);
      tick();
      tick();
      drive(1, 0, r[0], 0, 5, 0);
      tick();
      idle(12);
      check(r ? "t4_high_ren1" : "t4_high_ren0", 32'(hi_cnt), r ? 32'd8 : 32'd5);
      check("t4_done", 32'(done_cnt), 32'd1);
    end

    // 5. Cancel in the 2nd DELAY cycle, cancel in the 2nd INHIBIT cycle, and cancel+trigger in IDLE.
    done_cnt = 0;
    drive(1, 0, 0, 4, 3, 0);
    tick();
    drive(0, 0, 0, 4, 3, 0);
    tick();
    drive(0, 1, 0, 4, 3, 0);
    tick();
    check("t5a_busy", 32'(busy), 32'd0);
    idle(10);
    drive(1, 0, 0, 0, 6, 0);
    tick();
    drive(0, 0, 0, 0, 6, 0);
    tick();
    drive(0, 1, 0, 0, 6, 0);
    tick();
    check("t5b_enable_l", 32'(enable_l), 32'd0);
    idle(10);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    drive(1, 1, 0, 0, 6, 0);
    tick();
    check("t5c_no_start", 32'(busy), 32'd0);
    idle(2);

    // 6. Saturation at 3, a held count outside the window, clear on restart, and a level-high in.
    drive(1, 0, 0, 0, 20, 0);
    tick();
    for (int p = 0; p < 5; p++) begin
      drive(0, 0, 0, 0, 20, 1); tick();
      drive(0, 0, 0, 0, 20, 0); tick();
    end
    check("t6_saturate", 32'(suppressed_count), 32'd3);
    idle(14);
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    check("t6_hold_idle", 32'(suppressed_count), 32'd3);
    drive(1, 0, 0, 0, 20, 0);
    tick();
    check("t6_clear", 32'(suppressed_count), 32'd0);
    drive(0, 0, 0, 0, 20, 1);
    for (int i = 0; i < 10; i++) tick();
    check("t6_level_once", 32'(suppressed_count), 32'd1);
    idle(15);

    // Maximum delay and hold values do not overflow the counter.
    hi_cnt = 0;
    drive(1, 0, 0, 255, 255, 0);
    tick();
    idle(515);
    check("max_high", 32'(hi_cnt), 32'd255);

    // Randomized run checked against the timeline model.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 499) == 0);
      trigger      = ($urandom_range(0, 5) == 0);
      cancel       = ($urandom_range(0, 39) == 0);
      if (i % 50 == 0) retrigger_en = $urandom_range(0, 1) == 1;
      delay_cycles = WIDTH'($urandom_range(0, 6));
      hold_cycles  = WIDTH'($urandom_range(0, 8));
      in_s         = ($urandom_range(0, 2) == 0);
      tick();
    end
    reset = 1'b0;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
